// File: rtl/surf4_serial_wb_pkg.sv
// Shared constants for the serial-to-WISHBONE bridge: command codes, response status codes,
// parser state encoding and the response-length helper.
package surf4_serial_wb_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h57;
  localparam logic [7:0] CMD_READ   = 8'h52;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_ERR     = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;
  localparam logic [7:0] ST_BADCMD  = 8'h03;
  localparam logic [7:0] ST_RTY     = 8'h04;

  typedef enum logic [2:0] {
    StIdle,
    StAdrHi,
    StAdrLo,
    StData,
    StBus,
    StResp
  } state_e;

  // Write responses carry only the status byte; reads add four data bytes.
  function automatic logic [2:0] resp_len(input logic is_write);
    return is_write ? 3'd1 : 3'd5;
  endfunction

endpackage

// File: rtl/surf4_serial_wb_txser.sv
// Response serializer: loads up to five bytes (status + optional data) and emits them MSB
// first on a valid/ready byte stream.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   load_i            load data_i/len_i and start emitting (only pulsed while idle)
//   data_i[39:0]      response bytes, first byte in [39:32]
//   len_i[2:0]        number of bytes to emit (1 or 5)
//   tx_dat_o/valid_o  byte output, held stable until tx_ready_i
//   tx_ready_i        downstream accepts
//   done_o            high in the cycle the last byte is accepted
module surf4_serial_wb_txser (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [39:0] data_i,
  input  logic [2:0]  len_i,
  output logic [7:0]  tx_dat_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        done_o
);

  logic [39:0] sh_q;
  logic [2:0]  cnt_q;
  logic        valid_q;
  logic        fire;

  assign fire       = valid_q && tx_ready_i;
  assign tx_dat_o   = sh_q[39:32];
  assign tx_valid_o = valid_q;
  assign done_o     = fire && (cnt_q == 3'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      sh_q    <= data_i;
      cnt_q   <= len_i;
      valid_q <= (len_i != 3'd0);
    end else if (fire) begin
      sh_q  <= {sh_q[31:0], 8'h00};
      cnt_q <= cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/surf4_serial_wb_master.sv
// Byte-stream to WISHBONE classic bus master. Parses write (57 AH AL D3 D2 D1 D0) and read
// (52 AH AL) frames, runs one single-beat bus cycle per frame and returns a status byte,
// followed by four data bytes for reads.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   wb_*                         WISHBONE master (16-bit byte address, 32-bit data)
//   rx_dat_i/valid_i/ready_o     command byte stream
//   tx_dat_o/valid_o/ready_i     response byte stream
//   busy_o                       parser not idle
//   timeout_o                    one-cycle pulse when a bus cycle is abandoned
module surf4_serial_wb_master
  import surf4_serial_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RX_GAP_CYCLES  = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [15:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  input  logic [7:0]  rx_dat_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_dat_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GapLast = 32'(RX_GAP_CYCLES - 1);

  state_e      state_q;
  logic        is_wr_q;
  logic [15:0] adr_q;
  logic [31:0] wdat_q;
  logic [31:0] rdat_q;
  logic [7:0]  status_q;
  logic [2:0]  len_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] gap_q;
  logic [31:0] tmo_q;
  logic        cyc_q;
  logic        we_q;
  logic        rx_ready_q;
  logic        timeout_q;
  logic        load_q;

  logic        rx_acc;
  logic        gap_expire;
  logic        bus_end;
  logic        tx_done;

  assign rx_acc     = rx_valid_i && rx_ready_q;
  assign gap_expire = (gap_q == GapLast);
  assign bus_end    = wb_err_i || wb_rty_i || wb_ack_i || (tmo_q == TmoLast);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      is_wr_q    <= 1'b0;
      adr_q      <= '0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      status_q   <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      rx_ready_q <= 1'b0;
      timeout_q  <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      load_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          rx_ready_q <= 1'b1;
          gap_q      <= '0;
          if (rx_acc) begin
            if (rx_dat_i == CMD_WRITE || rx_dat_i == CMD_READ) begin
              is_wr_q <= (rx_dat_i == CMD_WRITE);
              state_q <= StAdrHi;
            end else begin
              status_q   <= ST_BADCMD;
              len_q      <= 3'd1;
              load_q     <= 1'b1;
              rx_ready_q <= 1'b0;
              state_q    <= StResp;
            end
          end
        end
        StAdrHi: begin
          if (rx_acc) begin
            adr_q[15:8] <= rx_dat_i;
            gap_q       <= '0;
            state_q     <= StAdrLo;
          end else if (gap_expire) begin
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q + 32'd1;
          end
        end
        StAdrLo: begin
          if (rx_acc) begin
            // Word-aligned slaves only: low address bits are dropped.
            adr_q[7:0] <= {rx_dat_i[7:2], 2'b00};
            gap_q      <= '0;
            if (is_wr_q) begin
              byte_cnt_q <= '0;
              state_q    <= StData;
            end else begin
              cyc_q      <= 1'b1;
              we_q       <= 1'b0;
              tmo_q      <= '0;
              rdat_q     <= '0;
              rx_ready_q <= 1'b0;
              state_q    <= StBus;
            end
          end else if (gap_expire) begin
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q + 32'd1;
          end
        end
        StData: begin
          if (rx_acc) begin
            wdat_q     <= {wdat_q[23:0], rx_dat_i};
            gap_q      <= '0;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              cyc_q      <= 1'b1;
              we_q       <= 1'b1;
              tmo_q      <= '0;
              rdat_q     <= '0;
              rx_ready_q <= 1'b0;
              state_q    <= StBus;
            end
          end else if (gap_expire) begin
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q + 32'd1;
          end
        end
        StBus: begin
          if (bus_end) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            load_q  <= 1'b1;
            len_q   <= resp_len(is_wr_q);
            state_q <= StResp;
            // err beats rty beats ack when several terminate together.
            if (wb_err_i) begin
              status_q <= ST_ERR;
            end else if (wb_rty_i) begin
              status_q <= ST_RTY;
            end else if (wb_ack_i) begin
              status_q <= ST_OK;
              if (!we_q) begin
                rdat_q <= wb_dat_i;
              end
            end else begin
              status_q  <= ST_TIMEOUT;
              timeout_q <= 1'b1;
            end
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        StResp: begin
          if (tx_done) begin
            rx_ready_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = wdat_q;
  assign wb_sel_o   = {4{cyc_q}};
  assign rx_ready_o = rx_ready_q;
  assign busy_o     = (state_q != StIdle);
  assign timeout_o  = timeout_q;

  surf4_serial_wb_txser u_txser (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load_q),
    .data_i     ({status_q, rdat_q}),
    .len_i      (len_q),
    .tx_dat_o   (tx_dat_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .done_o     (tx_done)
  );

endmodule

// File: tb/tb_surf4_serial_wb_master.sv
// Scoreboard bench: stimulus pushes expected response bytes and bus transactions into queues;
// a monitor pops and compares whenever the DUT hands over a byte or ends a bus cycle.
module tb_surf4_serial_wb_master;

  localparam int unsigned TMO = 255;
  localparam int unsigned GAP = 300;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [31:0] dat;
    int          len;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [15:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i;
  logic [7:0]  rx_dat = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_dat_o;
  logic        tx_valid_o;
  logic        tx_ready = 1'b1;
  logic        busy_o, timeout_o;

  always #5 clk = ~clk;

  surf4_serial_wb_master #(
    .TIMEOUT_CYCLES (TMO),
    .RX_GAP_CYCLES  (GAP)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i),
    .wb_rty_i   (wb_rty_i),
    .rx_dat_i   (rx_dat),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready_o),
    .tx_dat_o   (tx_dat_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o)
  );

  // Slave model: mode 0 silent, 1 ack, 2 err+ack, 3 rty; responds after slv_wait wait states.
  int          slv_mode  = 0;
  int          slv_wait  = 0;
  logic [31:0] slv_rdata = 32'h0;
  int          wcnt      = 0;
  logic        hit;

  always @(posedge clk) begin
    if (!wb_cyc_o) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  assign hit      = wb_cyc_o && wb_stb_o && (wcnt == slv_wait);
  assign wb_ack_i = hit && (slv_mode == 1 || slv_mode == 2);
  assign wb_err_i = hit && (slv_mode == 2);
  assign wb_rty_i = hit && (slv_mode == 3);
  assign wb_dat_i = slv_rdata;

  int passed = 0;
  int total  = 0;
  logic [7:0] tx_exp[$];
  bus_t       bus_exp[$];
  int timeout_cnt = 0;
  int cyc_starts  = 0;

  task automatic chk_ok(input bit ok, input string name, input logic [63:0] act,
                        input logic [63:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_ok(act === exp, name, act, exp);
  endtask

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  initial begin : monitor
    bit          in_cyc;
    int          cyc_len;
    logic        cap_we;
    logic [15:0] cap_adr;
    logic [31:0] cap_dat;
    logic [3:0]  cap_sel;
    logic [7:0]  te;
    bus_t        be;
    in_cyc  = 1'b0;
    cyc_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_cyc = 1'b0;
      end else begin
        if (timeout_o) timeout_cnt++;
        if (tx_valid_o && tx_ready) begin
          if (tx_exp.size() == 0) begin
            chk_ok(1'b0, "tx_unexpected", tx_dat_o, 0);
          end else begin
            te = tx_exp.pop_front();
            chk("tx_byte", tx_dat_o, te);
          end
        end
        if (wb_cyc_o) begin
          if (!in_cyc) begin
            in_cyc  = 1'b1;
            cyc_len = 0;
            cap_we  = wb_we_o;
            cap_adr = wb_adr_o;
            cap_dat = wb_dat_o;
            cap_sel = wb_sel_o;
            cyc_starts++;
          end
          cyc_len++;
        end else if (in_cyc) begin
          in_cyc = 1'b0;
          if (bus_exp.size() == 0) begin
            chk_ok(1'b0, "bus_unexpected", cap_adr, 0);
          end else begin
            be = bus_exp.pop_front();
            chk("bus_we", cap_we, be.we);
            chk("bus_adr", cap_adr, be.adr);
            if (be.we) chk("bus_dat", cap_dat, be.dat);
            chk("bus_sel", cap_sel, 4'hF);
            chk("bus_len", cyc_len, be.len);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_dat   = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready_o) begin
      chk_ok(1'b0, "rx_accept_wait", b, 0);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send_byte(f[i]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy_o || !rx_ready_o) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_ok(!busy_o && rx_ready_o, name, {busy_o, rx_ready_o}, 2'b01);
  endtask

  task automatic exp_read(input logic [7:0] st, input logic [31:0] d);
    tx_exp.push_back(st);
    for (int i = 3; i >= 0; i--) tx_exp.push_back(d[i*8+:8]);
  endtask

  task automatic exp_bus(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                         input int len);
    bus_t b;
    b.we  = we;
    b.adr = adr;
    b.dat = dat;
    b.len = len;
    bus_exp.push_back(b);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] frm[$];
    logic [7:0] hold;
    bit         stable;
    int         n;
    int         starts;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, tx_valid_o, rx_ready_o,
                        busy_o, timeout_o}, 0);
    chk("rst_adr_dat", {wb_adr_o, wb_dat_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rx_ready_after_rst", rx_ready_o, 1'b1);

    // Write, ack in the first bus cycle.
    slv_mode = 1; slv_wait = 0;
    exp_bus(1'b1, 16'h0018, 32'h00001001, 1);
    tx_exp.push_back(8'h00);
    frm = '{8'h57, 8'h00, 8'h18, 8'h00, 8'h00, 8'h10, 8'h01};
    send_frame(frm);
    chk("cyc_one_clock_after_last_byte", wb_cyc_o, 1'b1);
    wait_idle("idle_after_write");

    // Read, ack after 3 wait states.
    slv_mode = 1; slv_wait = 3; slv_rdata = 32'h53344137;
    exp_bus(1'b0, 16'h0000, 32'h0, 4);
    exp_read(8'h00, 32'h53344137);
    frm = '{8'h52, 8'h00, 8'h00};
    send_frame(frm);
    wait_idle("idle_after_read");

    // Read with silent slave: timeout.
    slv_mode = 0; timeout_cnt = 0;
    exp_bus(1'b0, 16'h0100, 32'h0, int'(TMO));
    exp_read(8'h02, 32'h0);
    frm = '{8'h52, 8'h01, 8'h00};
    send_frame(frm);
    wait_idle("idle_after_timeout");
    chk("timeout_pulses", timeout_cnt, 1);

    // Unknown command byte.
    starts = cyc_starts;
    tx_exp.push_back(8'h03);
    send_byte(8'hAA);
    wait_idle("idle_after_badcmd");
    chk("badcmd_no_cycle", cyc_starts, starts);

    // Partial frame then silence: discarded after exactly GAP idle cycles.
    starts = cyc_starts;
    frm = '{8'h57, 8'h00};
    send_frame(frm);
    n = 0;
    while (busy_o && n < int'(GAP) + 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("gap_cycles", n, GAP);
    chk("gap_no_cycle", cyc_starts, starts);
    wait_idle("idle_after_gap");

    // Read from 0x0004.
    slv_mode = 1; slv_wait = 0; slv_rdata = 32'hDEADBEEF;
    exp_bus(1'b0, 16'h0004, 32'h0, 1);
    exp_read(8'h00, 32'hDEADBEEF);
    frm = '{8'h52, 8'h00, 8'h04};
    send_frame(frm);
    wait_idle("idle_after_read4");

    // err and ack together: err wins. Low address bits dropped.
    slv_mode = 2; slv_wait = 1;
    exp_bus(1'b1, 16'h0008, 32'h11223344, 2);
    tx_exp.push_back(8'h01);
    frm = '{8'h57, 8'h00, 8'h0B, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(frm);
    wait_idle("idle_after_err");

    // Retry termination on a read: status only, data zeroed.
    slv_mode = 3; slv_wait = 0; slv_rdata = 32'hFFFFFFFF;
    exp_bus(1'b0, 16'h000C, 32'h0, 1);
    exp_read(8'h04, 32'h0);
    frm = '{8'h52, 8'h00, 8'h0C};
    send_frame(frm);
    wait_idle("idle_after_rty");

    // Backpressure mid-response.
    slv_mode = 1; slv_wait = 0; slv_rdata = 32'h0A0B0C0D;
    tx_ready = 1'b0;
    exp_bus(1'b0, 16'h0010, 32'h0, 1);
    exp_read(8'h00, 32'h0A0B0C0D);
    frm = '{8'h52, 8'h00, 8'h10};
    send_frame(frm);
    n = 0;
    while (!tx_valid_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_tx_valid", tx_valid_o, 1'b1);
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    hold   = tx_dat_o;
    stable = 1'b1;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (tx_dat_o !== hold || !tx_valid_o) stable = 1'b0;
    end
    chk("bp_stable", stable, 1'b1);
    chk("bp_held_byte", hold, 8'h0B);
    tx_ready = 1'b1;
    wait_idle("idle_after_bp");

    // Reset during a bus cycle.
    slv_mode = 0;
    frm = '{8'h52, 8'h00, 8'h20};
    send_frame(frm);
    chk("cyc_before_reset", wb_cyc_o, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset_drop", {wb_cyc_o, wb_stb_o, tx_valid_o}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rx_ready_after_midreset", {rx_ready_o, busy_o}, 2'b10);

    slv_mode = 1; slv_wait = 1; slv_rdata = 32'h12345678;
    exp_bus(1'b0, 16'h0024, 32'h0, 2);
    exp_read(8'h00, 32'h12345678);
    frm = '{8'h52, 8'h00, 8'h24};
    send_frame(frm);
    wait_idle("idle_after_reset_read");

    repeat (5) @(posedge clk);
    #1;
    chk("tx_queue_drained", tx_exp.size(), 0);
    chk("bus_queue_drained", bus_exp.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
